// File: rtl/serdes_pkg.sv
// Shared constants and types for the serializer transmit scheduler.
package serdes_pkg;

  localparam int SYM_W        = 10;
  localparam int BITS_PER_SYM = 10;

  // K28.5 comma in both running disparities.
  localparam logic [SYM_W-1:0] K28_5_RDN = 10'b0011111010;
  localparam logic [SYM_W-1:0] K28_5_RDP = 10'b1100000101;

  typedef enum logic {
    ALIGN = 1'b0,
    RUN   = 1'b1
  } state_t;

  // Line polarity inversion applied to every symbol as it is loaded.
  function automatic logic [SYM_W-1:0] apply_pol(input logic [SYM_W-1:0] sym,
                                                 input logic inv);
    return inv ? ~sym : sym;
  endfunction

endpackage

// File: rtl/serdes_tx_sched_if.sv
// Requester/serializer bundle between the link layer, the scheduler and par2ser.
interface serdes_tx_sched_if
  import serdes_pkg::*;
#(
  parameter int NREQ = 2
);
  logic                    en;
  logic                    txpol;
  logic [NREQ-1:0]         req;
  logic [NREQ*SYM_W-1:0]   data_in;
  logic [NREQ-1:0]         ack;
  logic [SYM_W-1:0]        sym_out;
  logic                    load;
  logic [3:0]              bit_idx;
  logic                    link_up;

  // Link-layer side: offers symbols, watches acks and the slot timing.
  modport master (
    output en, txpol, req, data_in,
    input  ack, sym_out, load, bit_idx, link_up
  );

  // Scheduler side.
  modport slave (
    input  en, txpol, req, data_in,
    output ack, sym_out, load, bit_idx, link_up
  );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after rr_ptr.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   rr_ptr,
  output logic [NREQ-1:0] grant,
  output logic [PW-1:0]   grant_idx,
  output logic            any_req
);

  logic [PW:0]   sum;
  logic [PW-1:0] idx;

  // Scan NREQ positions starting at rr_ptr, wrapping modulo NREQ.
  always_comb begin
    // NOTE: every output and temporary gets a default before the loop, so no
    // path through this block leaves a value unassigned and no latch is inferred.
    grant     = '0;
    grant_idx = '0;
    any_req   = 1'b0;
    sum       = '0;
    idx       = '0;
    for (int i = 0; i < NREQ; i++) begin
      sum = {1'b0, rr_ptr} + (PW+1)'(i);
      if (sum >= (PW+1)'(NREQ)) begin
        sum = sum - (PW+1)'(NREQ);
      end
      idx = sum[PW-1:0];
      if (!any_req && req[idx]) begin
        any_req    = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/serdes_tx_sched.sv
// Transmit scheduler: slot timing, alignment commas and round-robin symbol
// selection for a shared 10-bit serializer.
module serdes_tx_sched
  import serdes_pkg::*;
#(
  parameter int               NREQ      = 2,
  parameter int               ALIGN_CNT = 4,
  parameter logic [SYM_W-1:0] IDLE_SYM  = K28_5_RDN
) (
  input logic              reloj,
  input logic              reset,
  serdes_tx_sched_if.slave bus
);

  localparam int         PW         = $clog2(NREQ);
  localparam logic [3:0] LAST_BIT   = 4'(BITS_PER_SYM - 1);
  localparam logic [3:0] ALIGN_LAST = 4'(ALIGN_CNT - 2);

  state_t            state_q, state_d;
  logic [3:0]        bit_idx_q;
  logic [3:0]        align_cnt_q;
  logic [SYM_W-1:0]  sym_q;
  logic              load_q;
  logic [NREQ-1:0]   ack_q;
  logic [PW-1:0]     rr_ptr_q;

  logic              boundary;
  logic [NREQ-1:0]   grant;
  logic [PW-1:0]     grant_idx;
  logic              any_req;
  logic [SYM_W-1:0]  sel_sym;
  logic [PW-1:0]     ptr_next;

  assign boundary = bus.en && (bit_idx_q == LAST_BIT);

  rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_arb (
    .req       (bus.req),
    .rr_ptr    (rr_ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_req   (any_req)
  );

  // Symbol of the granted requester; the one-hot grant drives the mux.
  always_comb begin
    sel_sym = IDLE_SYM;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_sym = bus.data_in[i*SYM_W +: SYM_W];
      end
    end
  end

  assign ptr_next = (grant_idx == PW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;

  // Next state: leave ALIGN on the last alignment boundary; RUN is terminal.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ALIGN:   if (boundary && (align_cnt_q == ALIGN_LAST)) state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = ALIGN;
    endcase
  end

  // State register.
  always_ff @(posedge reloj or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) state_q <= ALIGN;
    else       state_q <= state_d;
  end

  // Bit counter, slot loading, round-robin pointer and output pulses.
  always_ff @(posedge reloj or posedge reset) begin
    if (reset) begin
      bit_idx_q   <= '0;
      align_cnt_q <= '0;
      sym_q       <= IDLE_SYM;
      load_q      <= 1'b0;
      ack_q       <= '0;
      rr_ptr_q    <= '0;
    end else begin
      load_q <= 1'b0;
      ack_q  <= '0;
      if (bus.en) begin
        bit_idx_q <= (bit_idx_q == LAST_BIT) ? 4'd0 : bit_idx_q + 4'd1;
      end
      if (boundary) begin
        load_q <= 1'b1;
        if (state_q == ALIGN) begin
          sym_q       <= apply_pol(IDLE_SYM, bus.txpol);
          align_cnt_q <= align_cnt_q + 4'd1;
        end else if (any_req) begin
          sym_q    <= apply_pol(sel_sym, bus.txpol);
          ack_q    <= grant;
          rr_ptr_q <= ptr_next;
        end else begin
          sym_q <= apply_pol(IDLE_SYM, bus.txpol);
        end
      end
    end
  end

  assign bus.sym_out = sym_q;
  assign bus.load    = load_q;
  assign bus.ack     = ack_q;
  assign bus.bit_idx = bit_idx_q;
  assign bus.link_up = (state_q == RUN);

endmodule

// File: tb/tb_serdes_tx_sched.sv
// Self-checking bench for serdes_tx_sched: directed scenarios with literal
// expectations plus a randomized run compared against a slot-level model.
module tb_serdes_tx_sched;
  import serdes_pkg::*;

  localparam int NREQ      = 2;
  localparam int ALIGN_CNT = 4;
  localparam logic [SYM_W-1:0] IDLE = 10'h0FA;

  logic reloj = 1'b0;
  logic reset = 1'b1;

  serdes_tx_sched_if #(.NREQ(NREQ)) bus ();

  serdes_tx_sched #(.NREQ(NREQ), .ALIGN_CNT(ALIGN_CNT), .IDLE_SYM(IDLE)) dut (
    .reloj (reloj),
    .reset (reset),
    .bus   (bus)
  );

  always #5 reloj = ~reloj;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  bit cmp_on   = 1'b0;
  int n        = 0;   // clock edges since the last reset release

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Tracks enabled cycles within a slot, the number of boundaries since reset
  // and the round-robin pointer as plain integers.
  int               m_phase, m_k, m_ptr;
  logic [SYM_W-1:0] exp_sym;
  logic             exp_load, exp_link;
  logic [NREQ-1:0]  exp_ack;

  task automatic m_reset();
    m_phase  = 0;
    m_k      = 0;
    m_ptr    = 0;
    exp_sym  = IDLE;
    exp_load = 1'b0;
    exp_ack  = '0;
    exp_link = 1'b0;
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge reloj or posedge reset);
      if (reset) m_reset();
      else begin
        exp_load = 1'b0;
        exp_ack  = '0;
        if (bus.en) begin
          if (m_phase == BITS_PER_SYM - 1) begin
            logic [SYM_W-1:0] s;
            bit found;
            m_k++;
            exp_load = 1'b1;
            s = IDLE;
            found = 1'b0;
            if (m_k >= ALIGN_CNT) begin
              for (int j = 0; j < NREQ; j++) begin
                int c;
                c = (m_ptr + j) % NREQ;
                if (!found && bus.req[c]) begin
                  found      = 1'b1;
                  s          = bus.data_in[c*SYM_W +: SYM_W];
                  exp_ack[c] = 1'b1;
                  m_ptr      = (c + 1) % NREQ;
                end
              end
            end
            exp_sym = bus.txpol ? ~s : s;
            if (m_k >= ALIGN_CNT - 1) exp_link = 1'b1;
          end
          m_phase = (m_phase + 1) % BITS_PER_SYM;
        end
      end
    end
  end

  // Compare DUT against the model on every falling edge.
  initial begin
    forever begin
      @(negedge reloj);
      if (cmp_on) begin
        check("cmp_bit_idx", 32'(bus.bit_idx), 32'(m_phase));
        check("cmp_sym_out", 32'(bus.sym_out), 32'(exp_sym));
        check("cmp_load",    32'(bus.load),    32'(exp_load));
        check("cmp_ack",     32'(bus.ack),     32'(exp_ack));
        check("cmp_link_up", 32'(bus.link_up), 32'(exp_link));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge reloj);
    #1;
    n++;
  endtask

  task automatic run_to(input int target);
    while (n < target) step();
  endtask

  task automatic set_req(input logic [NREQ-1:0] r, input logic [SYM_W-1:0] d0,
                         input logic [SYM_W-1:0] d1);
    bus.req     = r;
    bus.data_in = {d1, d0};
  endtask

  task automatic release_reset();
    @(posedge reloj);
    #1;
    reset = 1'b0;
    n     = 0;
  endtask

  initial begin
    bus.en      = 1'b1;
    bus.txpol   = 1'b0;
    bus.req     = '0;
    bus.data_in = '0;
    repeat (2) @(posedge reloj);
    release_reset();
    cmp_on = 1'b1;
    check("rst_sym_out", 32'(bus.sym_out), 32'(IDLE));
    check("rst_link_up", 32'(bus.link_up), 32'd0);

    // Alignment: commas at edges 10..40, link up after edge 30, no acks.
    for (int e = 1; e <= 40; e++) begin
      step();
      if (e % 10 == 0) begin
        check("align_load", 32'(bus.load), 32'd1);
        check("align_sym",  32'(bus.sym_out), 32'(IDLE));
        check("align_bit0", 32'(bus.bit_idx), 32'd0);
      end
      if (e == 9)  check("align_noload9", 32'(bus.load), 32'd0);
      if (e == 29) check("link_before", 32'(bus.link_up), 32'd0);
      if (e == 30) check("link_after",  32'(bus.link_up), 32'd1);
      check("align_ack0", 32'(bus.ack), 32'd0);
    end

    // Both requesters held: 0x155, 0x2AA, 0x155, then idle.
    run_to(45); set_req(2'b11, 10'h155, 10'h2AA);
    run_to(50); check("rr_sym1", 32'(bus.sym_out), 32'h155); check("rr_ack1", 32'(bus.ack), 32'h1);
    run_to(60); check("rr_sym2", 32'(bus.sym_out), 32'h2AA); check("rr_ack2", 32'(bus.ack), 32'h2);
    run_to(70); check("rr_sym3", 32'(bus.sym_out), 32'h155); check("rr_ack3", 32'(bus.ack), 32'h1);
    set_req(2'b00, 10'h155, 10'h2AA);
    run_to(80); check("rr_idle", 32'(bus.sym_out), 32'(IDLE)); check("rr_idle_ack", 32'(bus.ack), 32'h0);

    // Only req[1], then both: grant order 1, 0, 1.
    run_to(81); set_req(2'b10, 10'h155, 10'h2AA);
    run_to(90); check("wrap_ack1", 32'(bus.ack), 32'h2);
    set_req(2'b11, 10'h155, 10'h2AA);
    run_to(100); check("wrap_ack2", 32'(bus.ack), 32'h1);
    run_to(110); check("wrap_ack3", 32'(bus.ack), 32'h2);
    set_req(2'b00, 10'h155, 10'h2AA);

    // Polarity inversion at a boundary; mid-symbol toggle has no effect.
    run_to(115); set_req(2'b01, 10'h155, 10'h000);
    run_to(118); bus.txpol = 1'b1;
    run_to(120); check("pol_inv", 32'(bus.sym_out), 32'h2AA);
    set_req(2'b00, 10'h155, 10'h000);
    run_to(124); bus.txpol = 1'b0;
    run_to(125); check("pol_mid", 32'(bus.sym_out), 32'h2AA);
    run_to(130); check("pol_idle", 32'(bus.sym_out), 32'(IDLE));

    // en low on the bit 9 cycle postpones the boundary.
    run_to(139); check("en_bit9", 32'(bus.bit_idx), 32'd9);
    bus.en = 1'b0;
    for (int e = 0; e < 3; e++) begin
      step();
      check("en_hold_load", 32'(bus.load), 32'd0);
      check("en_hold_bit",  32'(bus.bit_idx), 32'd9);
    end
    bus.en = 1'b1;
    run_to(143); check("en_bnd_load", 32'(bus.load), 32'd1); check("en_bnd_bit", 32'(bus.bit_idx), 32'd0);
    run_to(152); check("en_next_noload", 32'(bus.load), 32'd0);
    run_to(153); check("en_next_load", 32'(bus.load), 32'd1);

    // Reset mid-symbol with req[0] pending: immediate reset values, realign.
    run_to(156); set_req(2'b01, 10'h155, 10'h000);
    run_to(158); check("mid_bit5", 32'(bus.bit_idx), 32'd5);
    reset = 1'b1;
    #1;
    check("mid_rst_bit",  32'(bus.bit_idx), 32'd0);
    check("mid_rst_sym",  32'(bus.sym_out), 32'(IDLE));
    check("mid_rst_ack",  32'(bus.ack),     32'd0);
    check("mid_rst_link", 32'(bus.link_up), 32'd0);
    release_reset();
    for (int e = 1; e <= 40; e++) begin
      step();
      if (e < 40) check("realign_ack0", 32'(bus.ack), 32'd0);
      if (e == 30) check("realign_sym", 32'(bus.sym_out), 32'(IDLE));
    end
    check("realign_serve_sym", 32'(bus.sym_out), 32'h155);
    check("realign_serve_ack", 32'(bus.ack), 32'h1);
    set_req(2'b00, 10'h000, 10'h000);

    // Randomized traffic under the model.
    for (int c = 0; c < 3000; c++) begin
      step();
      if (c == 1500) begin
        reset = 1'b1;
        repeat (2) step();
        reset = 1'b0;
      end
      bus.en = ($urandom_range(7) != 0);
      if ($urandom_range(15) == 0) bus.txpol = ~bus.txpol;
      for (int i = 0; i < NREQ; i++) begin
        if (bus.ack[i]) begin
          if ($urandom_range(1) == 0) bus.req[i] = 1'b0;
          else bus.data_in[i*SYM_W +: SYM_W] = SYM_W'($urandom);
        end else if (!bus.req[i]) begin
          if ($urandom_range(3) == 0) begin
            bus.req[i] = 1'b1;
            bus.data_in[i*SYM_W +: SYM_W] = SYM_W'($urandom);
          end
        end else if ($urandom_range(49) == 0) begin
          bus.req[i] = 1'b0;
        end
      end
    end

    cmp_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
